// File: rtl/shift_register.sv
// shift_register: universal shift register with synchronous load, hold and bidirectional serial shift
module shift_register #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] out
);
  // select-driven register update; unknown select falls through to hold
  always_ff @(posedge clk) begin
    if (reset) out <= '0;
    else
      case (select)
        2'b01:   out <= {serial_in, out[WIDTH-1:1]};
        2'b10:   out <= {out[WIDTH-2:0], serial_in};
        2'b11:   out <= parallel_in;
        default: out <= out;
      endcase
  end
endmodule

// File: tb/tb_shift_register.sv
// tb_shift_register: directed and randomized checks of shift_register against a bit-array model
module tb_shift_register;
  localparam int W = 4;
  logic clk = 0, reset, serial_in;
  logic [W-1:0] parallel_in, out;
  logic [1:0] select;
  int tests = 0, fails = 0;
  bit m [W];
  shift_register #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .serial_in(serial_in), .parallel_in(parallel_in), .select(select), .out(out));
  always #5 clk = ~clk;
  function automatic logic [W-1:0] model_val();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = m[i];
    return v;
  endfunction
  task automatic model_step(input bit r, input int sel, input bit si, input logic [W-1:0] pi);
    bit t [W];
    t = m;
    if (r) foreach (m[i]) m[i] = 0;
    else if (sel == 1) begin
      for (int i = 0; i < W - 1; i++) m[i] = t[i+1];
      m[W-1] = si;
    end else if (sel == 2) begin
      for (int i = W - 1; i > 0; i--) m[i] = t[i-1];
      m[0] = si;
    end else if (sel == 3) foreach (m[i]) m[i] = pi[i];
  endtask
  task automatic step(input bit r, input logic [1:0] sel, input bit si, input logic [W-1:0] pi, input string tag);
    reset = r; select = sel; serial_in = si; parallel_in = pi;
    @(posedge clk);
    model_step(r, int'(sel), si, pi);
    #1;
    tests++;
    assert (out === model_val()) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, out, model_val());
    end
  endtask
  task automatic exp(input logic [W-1:0] e, input string tag);
    tests++;
    assert (out === e) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, out, e);
    end
  endtask
  initial begin
    foreach (m[i]) m[i] = 0;
    step(1, 2'b11, 0, 4'hF, "reset0"); exp(4'h0, "reset0c");
    step(1, 2'b11, 1, 4'hF, "reset1"); exp(4'h0, "reset1c");
    step(0, 2'b11, 0, 4'b1011, "load"); exp(4'b1011, "loadc");
    for (int i = 0; i < 3; i++) step(0, 2'b00, i[0], i[0] ? 4'h0 : 4'hF, "hold");
    exp(4'b1011, "holdc");
    step(0, 2'b01, 1, 4'h0, "sr1"); exp(4'b1101, "sr1c");
    step(0, 2'b01, 0, 4'hF, "sr2"); exp(4'b0110, "sr2c");
    step(0, 2'b01, 0, 4'h0, "sr3"); exp(4'b0011, "sr3c");
    step(0, 2'b01, 1, 4'h0, "sr4"); exp(4'b1001, "sr4c");
    step(0, 2'b11, 0, 4'b0001, "ld1");
    step(0, 2'b10, 0, 4'hF, "sl1"); exp(4'b0010, "sl1c");
    step(0, 2'b10, 0, 4'h0, "sl2"); exp(4'b0100, "sl2c");
    step(0, 2'b10, 0, 4'h0, "sl3"); exp(4'b1000, "sl3c");
    step(0, 2'b10, 1, 4'h0, "sl4"); exp(4'b0001, "sl4c");
    step(0, 2'b11, 0, 4'b1111, "ldf");
    step(0, 2'b01, 0, 4'h0, "mid_sr"); exp(4'b0111, "mid_src");
    step(1, 2'b01, 1, 4'h0, "mid_rst"); exp(4'b0000, "mid_rstc");
    step(0, 2'b10, 1, 4'h0, "mid_sl"); exp(4'b0001, "mid_slc");
    step(0, 2'b11, 0, 4'b1010, "b2b_ld"); exp(4'b1010, "b2b_ldc");
    step(0, 2'b01, 0, 4'h0, "b2b_r"); exp(4'b0101, "b2b_rc");
    step(0, 2'b10, 1, 4'h0, "b2b_l"); exp(4'b1011, "b2b_lc");
    step(0, 2'b00, 0, 4'h0, "b2b_h"); exp(4'b1011, "b2b_hc");
    step(0, 2'bxx, 1, 4'h0, "xsel"); exp(4'b1011, "xselc");
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)), 1'($urandom), 4'($urandom), "rand");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
